collision_scan: RTL and testbench

// - Builds the 8-bit per-direction collision vector consumed by the two-hero movement controller.
// - Time-shares one wall-map ROM read port across 16 probe points: 2 heroes x 4 directions x 2 corners.
// - Started once per movement tick; the vector updates atomically at the end of each scan.
// - Sits between hero position registers, the wall-map ROM and the movement controller.

---
 rtl/game_pkg.sv | 69 ++++++
 rtl/collision_scan_if.sv | 24 ++
 rtl/collision_scan_pix_to_tile.sv | 29 ++
 rtl/collision_scan.sv | 97 +++++++++
 tb/tb_collision_scan.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Playfield geometry, collision-vector bit layout and probe geometry shared by
// the collision scanner and the movement controller.
package game_pkg;
    localparam int SIDE   = 60;
    localparam int TILE   = 60;
    localparam int X0     = 62;
    localparam int Y0     = 108;
    localparam int COLS   = 15;
    localparam int ROWS   = 10;
    localparam int ADDR_W = 8;
    localparam int TILE_W = 4;
    localparam int NPROBE = 16;

    localparam int COL_H0_L = 0;
    localparam int COL_H0_R = 1;
    localparam int COL_H0_D = 2;
    localparam int COL_H0_U = 3;
    localparam int COL_H1_L = 4;
    localparam int COL_H1_R = 5;
    localparam int COL_H1_D = 6;
    localparam int COL_H1_U = 7;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_U = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_COMMIT
    } scan_state_t;

    typedef struct packed {
        logic [11:0] px;
        logic [11:0] py;
    } point_t;

    // Pixel just outside the hero square on the given side; corner selects
    // which end of that edge. All arithmetic wraps at 12 bits.
    function automatic point_t probe_point(logic [11:0] x, logic [11:0] y,
                                           dir_t d, logic corner);
        point_t pt;
        pt.px = x;
        pt.py = y;
        case (d)
            DIR_L: begin
                pt.px = x - 12'd1;
                pt.py = corner ? y + 12'(SIDE - 1) : y;
            end
            DIR_R: begin
                pt.px = x + 12'(SIDE);
                pt.py = corner ? y + 12'(SIDE - 1) : y;
            end
            DIR_D: begin
                pt.px = corner ? x + 12'(SIDE - 1) : x;
                pt.py = y + 12'(SIDE);
            end
            default: begin
                pt.px = corner ? x + 12'(SIDE - 1) : x;
                pt.py = y - 12'd1;
            end
        endcase
        return pt;
    endfunction
endpackage

// File: rtl/collision_scan_if.sv
// Scan request/result handshake plus the wall-map ROM read port.
interface collision_scan_if;
    import game_pkg::*;

    logic              start;
    logic [23:0]       x_pos;
    logic [23:0]       y_pos;
    logic [ADDR_W-1:0] map_addr;
    logic              map_rd;
    logic              map_data;
    logic              busy;
    logic              done;
    logic [7:0]        collision;

    modport slave (
        input  start, x_pos, y_pos, map_data,
        output map_addr, map_rd, busy, done, collision
    );

    modport master (
        output start, x_pos, y_pos, map_data,
        input  map_addr, map_rd, busy, done, collision
    );
endinterface

// File: rtl/collision_scan_pix_to_tile.sv
// Pixel coordinate to wall-map tile, using a compare ladder instead of a divider.
module pix_to_tile
    import game_pkg::*;
(
    input  logic [11:0]       px,
    input  logic [11:0]       py,
    output logic [TILE_W-1:0] col,
    output logic [TILE_W-1:0] row,
    output logic              oob
);
    logic [11:0] dx;
    logic [11:0] dy;

    assign dx = px - 12'(X0);
    assign dy = py - 12'(Y0);

    // Underflowed coordinates wrap high and fall out through the upper bound.
    assign oob = (px < 12'(X0)) || (px >= 12'(X0 + COLS * TILE)) ||
                 (py < 12'(Y0)) || (py >= 12'(Y0 + ROWS * TILE));

    always_comb begin
        col = '0;
        row = '0;
        for (int k = 1; k < COLS; k++)
            if (dx >= 12'(k * TILE)) col = col + 1'b1;
        for (int k = 1; k < ROWS; k++)
            if (dy >= 12'(k * TILE)) row = row + 1'b1;
    end
endmodule

// File: rtl/collision_scan.sv
// Time-shares the wall-map ROM across 16 probe points and commits the
// resulting per-direction collision vector atomically once per scan.
module collision_scan
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    collision_scan_if.slave bus
);
    scan_state_t       state;
    logic [3:0]        p;
    logic [23:0]       snap_x;
    logic [23:0]       snap_y;
    logic [7:0]        acc;
    logic [7:0]        acc_next;
    logic              pend;
    logic              pend_oob;
    logic [2:0]        pend_bit;

    logic [11:0]       hx;
    logic [11:0]       hy;
    point_t            pt;
    logic [TILE_W-1:0] col;
    logic [TILE_W-1:0] row;
    logic              oob;

    assign hx = p[3] ? snap_x[23:12] : snap_x[11:0];
    assign hy = p[3] ? snap_y[23:12] : snap_y[11:0];
    assign pt = probe_point(hx, hy, dir_t'(p[2:1]), p[0]);

    pix_to_tile u_pix_to_tile (
        .px  (pt.px),
        .py  (pt.py),
        .col (col),
        .row (row),
        .oob (oob)
    );

    // OOB probes still occupy their read slot so the data pipeline stays aligned.
    assign bus.map_rd   = (state == S_ISSUE);
    assign bus.map_addr = (state != S_ISSUE || oob) ? '0 :
                          ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    always_comb begin
        acc_next = acc;
        if (pend && (pend_oob || bus.map_data))
            acc_next = acc | (8'd1 << pend_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            p             <= '0;
            snap_x        <= '0;
            snap_y        <= '0;
            acc           <= '0;
            pend          <= 1'b0;
            pend_oob      <= 1'b0;
            pend_bit      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.collision <= 8'hFF;
        end else begin
            bus.done <= 1'b0;
            pend     <= (state == S_ISSUE);
            pend_oob <= oob;
            pend_bit <= p[3:1];
            acc      <= acc_next;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        snap_x   <= bus.x_pos;
                        snap_y   <= bus.y_pos;
                        p        <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    p <= p + 4'd1;
                    if (p == 4'(NPROBE - 1)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Last probe's data lands this cycle; fold it in on the way out.
                    bus.collision <= acc_next;
                    bus.done      <= 1'b1;
                    state         <= S_COMMIT;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scan.sv
// Randomized and directed scans of collision_scan against a geometric reference model.
module tb_collision_scan;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   wall [0:149];
    logic [7:0] prev_col;

    collision_scan_if bus ();

    collision_scan dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Wall-map ROM: one cycle read latency.
    always @(posedge clk)
        bus.map_data <= (bus.map_rd && bus.map_addr < 8'd150) ? wall[bus.map_addr] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference geometry: side d (0 L,1 R,2 D,3 U), corner c, plain integer math.
    function automatic void ref_point(int x, int y, int d, int c, output int px, output int py);
        case (d)
            0: begin px = x - 1;                 py = c ? y + SIDE - 1 : y; end
            1: begin px = x + SIDE;              py = c ? y + SIDE - 1 : y; end
            2: begin px = c ? x + SIDE - 1 : x;  py = y + SIDE; end
            default: begin px = c ? x + SIDE - 1 : x; py = y - 1; end
        endcase
        px = px & 12'hFFF;
        py = py & 12'hFFF;
    endfunction

    function automatic bit ref_oob(int px, int py);
        return px < X0 || px >= X0 + COLS * TILE || py < Y0 || py >= Y0 + ROWS * TILE;
    endfunction

    function automatic int ref_addr(int px, int py);
        if (ref_oob(px, py)) return 0;
        return ((py - Y0) / TILE) * COLS + (px - X0) / TILE;
    endfunction

    function automatic int probe_addr(logic [23:0] x, logic [23:0] y, int p);
        int h, px, py;
        h = p / 8;
        ref_point(int'(x[12*h +: 12]), int'(y[12*h +: 12]), (p / 2) % 4, p % 2, px, py);
        return ref_addr(px, py);
    endfunction

    function automatic logic [7:0] ref_col(logic [23:0] x, logic [23:0] y);
        logic [7:0] r;
        int px, py;
        r = '0;
        for (int h = 0; h < 2; h++)
            for (int d = 0; d < 4; d++)
                for (int c = 0; c < 2; c++) begin
                    ref_point(int'(x[12*h +: 12]), int'(y[12*h +: 12]), d, c, px, py);
                    if (ref_oob(px, py) || wall[ref_addr(px, py)]) r[h*4 + d] = 1'b1;
                end
        return r;
    endfunction

    task automatic do_scan(input logic [23:0] x, input logic [23:0] y,
                           input bit perturb, input bit multi);
        logic [7:0] exp;
        int rd_cnt, done_cnt;
        exp = ref_col(x, y);
        rd_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.x_pos = x;
        bus.y_pos = y;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            bus.start = multi && (k == 5 || k == 18);
            if (perturb && k == 3) begin
                bus.x_pos = $urandom;
                bus.y_pos = $urandom;
            end
            chk("map_rd", bus.map_rd, k <= 16);
            if (bus.map_rd) rd_cnt++;
            if (k <= 16) chk("map_addr", bus.map_addr, probe_addr(x, y, k - 1));
            chk("busy", bus.busy, k <= 18);
            chk("done", bus.done, k == 18);
            if (bus.done) done_cnt++;
            if (k == 10) chk("collision_hold", bus.collision, prev_col);
            if (k == 18) chk("collision", bus.collision, exp);
        end
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        chk("rd_count", rd_cnt, 16);
        chk("done_count", done_cnt, 1);
        prev_col = exp;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x_pos = '0;
        bus.y_pos = '0;
        for (int i = 0; i < 150; i++) wall[i] = 1'b0;
        prev_col = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_collision", bus.collision, 8'hFF);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_map_rd", bus.map_rd, 0);
        chk("rst_map_addr", bus.map_addr, 0);
        rst = 1'b0;

        // Both heroes on the bottom row: only the down probes leave the field.
        do_scan({12'd422, 12'd542}, {12'd648, 12'd648}, 0, 0);
        chk("empty_bottom", prev_col, 8'h44);
        wall[144] = 1'b1;
        do_scan({12'd422, 12'd542}, {12'd648, 12'd648}, 0, 0);
        chk("wall_144", prev_col, 8'h46);
        wall[144] = 1'b0;

        do_scan({12'd300, 12'd62}, {12'd300, 12'd400}, 0, 0);
        do_scan({12'd500, 12'd0}, {12'd200, 12'd300}, 0, 1);
        do_scan({12'd700, 12'd200}, {12'd500, 12'd250}, 1, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.x_pos = {12'd400, 12'd400};
        bus.y_pos = {12'd400, 12'd400};
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_collision", bus.collision, 8'hFF);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_map_rd", bus.map_rd, 0);
        rst = 1'b0;
        prev_col = 8'hFF;
        do_scan({12'd422, 12'd542}, {12'd648, 12'd648}, 0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [23:0] rx, ry;
            for (int i = 0; i < 150; i++) wall[i] = ($urandom_range(0, 3) == 0);
            rx = {12'($urandom_range(0, 1000)), 12'($urandom_range(0, 1000))};
            ry = {12'($urandom_range(40, 780)), 12'($urandom_range(40, 780))};
            if (n % 5 == 0) rx[11:0] = 12'd0;
            do_scan(rx, ry, n % 3 == 0, n % 4 == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
